oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter REG_ADDR, default 'hFF46, CPU-visible DMA trigger/source register address.
REQ-002 SHALL have parameter DEST_BASE, default 'hFE00, first OAM destination address.
REQ-003 SHALL have parameter LEN, default 'hA0 (160), bytes per transfer.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-006 SHALL have port cpu_addr  input  16  CPU bus address (snooped).
REQ-007 SHALL have port cpu_data_write  input  8  CPU write data.
REQ-008 SHALL have port cpu_do_write  input  1  CPU write strobe.
REQ-009 SHALL have port reg_data_read  output  8  readback of source register.
REQ-010 SHALL have port reg_data_active  output  1  high when !cpu_do_write and cpu_addr == REG_ADDR.
REQ-011 SHALL have port dma_active  output  1  high while a transfer owns the bus; the bus mux selects DMA outputs when high.
REQ-012 SHALL have port dma_addr  output  16  address driven by DMA.
REQ-013 SHALL have port dma_data_write  output  8  write data driven by DMA.
REQ-014 SHALL have port dma_do_write  output  1  DMA write strobe.
REQ-015 SHALL have port dma_data_read  input  8  read data returned from the bus (combinational to dma_addr).
REQ-016 SHALL have port dma_data_valid  input  1  OR of all responders' mem_data_active for dma_addr.

Function
REQ-017 SHALL implement states IDLE, START, READ, WRITE in a registered state variable.
REQ-018 Trigger: at any rising edge with cpu_do_write=1 and cpu_addr==REG_ADDR, SHALL load src <= cpu_data_write, idx <= 0, state <= START, from any state.
REQ-019 Source high byte: src values 'hE0-'hFF SHALL be mapped to src-'h20 when forming addresses; the stored src (readback) SHALL stay unmapped.
REQ-020 START: one cycle, dma_active=1, dma_do_write=0, dma_addr=0; next state READ.
REQ-021 READ: dma_addr = {mapped_src, idx}, dma_do_write=0; at the exiting edge SHALL latch data <= dma_data_valid ? dma_data_read : 'hFF; next state WRITE.
REQ-022 WRITE: dma_addr = DEST_BASE + idx, dma_data_write = latched data, dma_do_write=1; at exit, if idx == LEN-1 next state IDLE, else idx <= idx+1 and next state READ.
REQ-023 dma_active SHALL be 1 in START, READ and WRITE, and 0 in IDLE.
REQ-024 In IDLE, dma_addr, dma_data_write and dma_do_write SHALL be 0.
REQ-025 idx SHALL be 8 bits; DEST_BASE+idx SHALL be a 16-bit sum; idx never exceeds LEN-1.
REQ-026 Latency: trigger edge T0 -> dma_active high from T0 to T0+2*LEN+1; exactly 2*LEN+1 active cycles (321 at default).
REQ-027 Retrigger during a transfer, including during the final WRITE, SHALL win over completion: the in-flight write still presents for that cycle, then START with idx=0.
REQ-028 CPU writes to other addresses SHALL be ignored; reg_data_read SHALL always equal src.

Reset
REQ-029 With reset low, SHALL asynchronously force state=IDLE, src=0, idx=0, data=0; all outputs 0 (dma_active, dma_addr, dma_data_write, dma_do_write, reg_data_read).
REQ-030 Reset asserted mid-transfer SHALL abort immediately with no further writes; after release the block SHALL remain IDLE until the next trigger.

Verification
REQ-031 Write 'hC1 to 'hFF46; memory C100-C19F = i^'h5A -> FE00-FE9F receive i^'h5A; dma_active high exactly 321 cycles; 160 write strobes.
REQ-032 Write 'hF0 -> READ addresses D000-D09F (echo mapping); reg_data_read = 'hF0.
REQ-033 Hold dma_data_valid=0 during source reads -> every OAM byte written 'hFF.
REQ-034 Write 'hC1, then 'hC2 at the 50th WRITE cycle -> restart at idx 0 from C200; FE00-FE9F end with C2xx data; dma_active continuous.
REQ-035 Pull reset low in the 10th READ -> all outputs 0 the same cycle, no further dma_do_write; reg_data_read = 0.
REQ-036 Read 'hFF46 with cpu_do_write=0 -> reg_data_active=1, value = last written src; any other address -> reg_data_active=0.

Source files
------------

// File: rtl/oam_dma.sv
// OAM DMA engine: snoops CPU writes to the trigger register and copies LEN bytes
// from {src,8'h00} (echo-mapped) into OAM at DEST_BASE with one READ/WRITE pair per byte.
module oam_dma #(
    parameter logic [15:0] REG_ADDR  = 16'hFF46,
    parameter logic [15:0] DEST_BASE = 16'hFE00,
    parameter int unsigned LEN       = 'hA0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_write,
    input  logic        cpu_do_write,
    output logic [7:0]  reg_data_read,
    output logic        reg_data_active,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_write,
    output logic        dma_do_write,
    input  logic [7:0]  dma_data_read,
    input  logic        dma_data_valid
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic [7:0] src_mapped;
    logic       reg_hit;
    logic       trigger;

    assign reg_hit         = (cpu_addr == REG_ADDR);
    assign trigger         = cpu_do_write & reg_hit;
    assign reg_data_active = ~cpu_do_write & reg_hit;
    assign reg_data_read   = src_q;

    // Sources E0-FF alias the echo region, so they fetch from C0-DF instead.
    always_comb begin
        if (src_q >= 8'hE0) begin
            src_mapped = src_q - 8'h20;
        end else begin
            src_mapped = src_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        idx_d          = idx_q;
        data_d         = data_q;
        dma_active     = 1'b0;
        dma_addr       = '0;
        dma_data_write = '0;
        dma_do_write   = 1'b0;

        case (state_q)
            IDLE: begin
            end
            START: begin
                dma_active = 1'b1;
                state_d    = READ;
            end
            READ: begin
                dma_active = 1'b1;
                dma_addr   = {src_mapped, idx_q};
                data_d     = dma_data_valid ? dma_data_read : 8'hFF;
                state_d    = WRITE;
            end
            WRITE: begin
                dma_active     = 1'b1;
                dma_addr       = DEST_BASE + {8'h00, idx_q};
                dma_data_write = data_q;
                dma_do_write   = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase

        // A retrigger overrides completion; the current cycle's outputs are unaffected.
        if (trigger) begin
            src_d   = cpu_data_write;
            idx_d   = '0;
            state_d = START;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: register-access vector table, directed transfer sequences
// and randomized transfers checked against a byte-level copy model.
module tb_oam_dma;

    localparam logic [15:0] REG_ADDR = 16'hFF46;
    localparam logic [15:0] DEST     = 16'hFE00;
    localparam int          LEN      = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_write;
    logic        cpu_do_write;
    logic [7:0]  reg_data_read;
    logic        reg_data_active;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_write;
    logic        dma_do_write;
    logic [7:0]  dma_data_read;
    logic        dma_data_valid;

    logic [7:0] mem [0:65535];
    bit         valid_map [0:65535];
    bit         force_invalid;

    assign dma_data_read  = mem[dma_addr];
    assign dma_data_valid = force_invalid ? 1'b0 : valid_map[dma_addr];

    oam_dma #(
        .REG_ADDR (16'hFF46),
        .DEST_BASE(16'hFE00),
        .LEN      (160)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_data_write (cpu_data_write),
        .cpu_do_write   (cpu_do_write),
        .reg_data_read  (reg_data_read),
        .reg_data_active(reg_data_active),
        .dma_active     (dma_active),
        .dma_addr       (dma_addr),
        .dma_data_write (dma_data_write),
        .dma_do_write   (dma_do_write),
        .dma_data_read  (dma_data_read),
        .dma_data_valid (dma_data_valid)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int          active_cnt;
    int          falls;
    bit          prev_active = 1'b0;
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [15:0] rd_addr_q[$];

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (dma_active) active_cnt++;
        if (prev_active && !dma_active) falls++;
        prev_active = dma_active;
        if (dma_do_write) begin
            wr_addr_q.push_back(dma_addr);
            wr_data_q.push_back(dma_data_write);
        end else if (dma_active) begin
            rd_addr_q.push_back(dma_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] src_addr(input logic [7:0] s, input int i);
        logic [7:0] hi;
        hi = (s >= 8'hE0) ? s - 8'h20 : s;
        return {hi, 8'(i)};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] s, input int i);
        logic [15:0] a;
        a = src_addr(s, i);
        return (!force_invalid && valid_map[a]) ? mem[a] : 8'hFF;
    endfunction

    task automatic clear_log();
        active_cnt = 0;
        falls      = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic trigger(input logic [7:0] s);
        @(negedge clk);
        cpu_addr       = REG_ADDR;
        cpu_data_write = s;
        cpu_do_write   = 1'b1;
        @(negedge clk);
        cpu_do_write = 1'b0;
        cpu_addr     = 16'h0000;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            #1;
            if (!dma_active) break;
        end
        chk("wait_idle", 32'(dma_active), 32'd0);
    endtask

    task automatic check_writes(input logic [7:0] s, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (base + i < wr_addr_q.size()) begin
                chk("wr_addr", 32'(wr_addr_q[base+i]), 32'(DEST + 16'(i)));
                chk("wr_data", 32'(wr_data_q[base+i]), 32'(exp_byte(s, i)));
            end else begin
                chk("wr_missing", 32'(base + i), 32'(wr_addr_q.size()));
            end
        end
    endtask

    task automatic retrigger(input logic [7:0] s, input int k);
        int n = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (dma_do_write) n++;
            if (n == k) break;
        end
        chk("retrig_reach", 32'(n), 32'(k));
        cpu_addr       = REG_ADDR;
        cpu_data_write = s;
        cpu_do_write   = 1'b1;
        @(negedge clk);
        cpu_do_write = 1'b0;
        cpu_addr     = 16'h0000;
    endtask

    task automatic check_outputs_zero();
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_addr", 32'(dma_addr), 32'd0);
        chk("rst_wdata", 32'(dma_data_write), 32'd0);
        chk("rst_we", 32'(dma_do_write), 32'd0);
        chk("rst_regrd", 32'(reg_data_read), 32'd0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
        logic        exp_act;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{16'hFF46, 8'h37, 1'b1, 1'b0, 8'h37};
        tbl[1]  = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'h37};
        tbl[2]  = '{16'hFF45, 8'h99, 1'b1, 1'b0, 8'h37};
        tbl[3]  = '{16'hFF47, 8'h99, 1'b1, 1'b0, 8'h37};
        tbl[4]  = '{16'hFF46, 8'hAA, 1'b0, 1'b1, 8'h37};
        tbl[5]  = '{16'hFF46, 8'hE5, 1'b1, 1'b0, 8'hE5};
        tbl[6]  = '{16'h0000, 8'h12, 1'b0, 1'b0, 8'hE5};
        tbl[7]  = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'hE5};
        tbl[8]  = '{16'h7F46, 8'h11, 1'b1, 1'b0, 8'hE5};
        tbl[9]  = '{16'hFF46, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{16'hFF46, 8'h5A, 1'b0, 1'b1, 8'h00};

        for (int i = 0; i < 65536; i++) begin
            mem[i]       = 8'($urandom);
            valid_map[i] = ($urandom_range(0, 9) != 0);
        end
        force_invalid  = 1'b0;
        reset          = 1'b0;
        cpu_addr       = '0;
        cpu_data_write = '0;
        cpu_do_write   = 1'b0;
        clear_log();

        repeat (3) @(negedge clk);
        check_outputs_zero();
        reset = 1'b1;

        // Register access table
        foreach (tbl[i]) begin
            @(negedge clk);
            cpu_addr       = tbl[i].addr;
            cpu_data_write = tbl[i].data;
            cpu_do_write   = tbl[i].we;
            #1;
            chk("reg_active", 32'(reg_data_active), 32'(tbl[i].exp_act));
            @(posedge clk);
            #1;
            chk("reg_read", 32'(reg_data_read), 32'(tbl[i].exp_rd));
        end
        @(negedge clk);
        cpu_do_write = 1'b0;
        cpu_addr     = '0;
        wait_idle(1000);

        // Basic copy from C100
        for (int i = 0; i < LEN; i++) begin
            mem[16'hC100 + 16'(i)]       = 8'(i) ^ 8'h5A;
            valid_map[16'hC100 + 16'(i)] = 1'b1;
        end
        clear_log();
        trigger(8'hC1);
        wait_idle(400);
        chk("A_active_cycles", 32'(active_cnt), 32'd321);
        chk("A_falls", 32'(falls), 32'd1);
        chk("A_strobes", 32'(wr_addr_q.size()), 32'd160);
        check_writes(8'hC1, 0, LEN);
        chk("A_byte0", 32'(wr_data_q[0]), 32'h5A);
        chk("A_byte159", 32'(wr_data_q[159]), 32'(8'd159 ^ 8'h5A));
        chk("A_regrd", 32'(reg_data_read), 32'hC1);

        // Echo-mapped source F0 reads D000-D09F
        clear_log();
        trigger(8'hF0);
        wait_idle(400);
        chk("B_reads", 32'(rd_addr_q.size()), 32'd161);
        if (rd_addr_q.size() == 161) begin
            chk("B_start_addr", 32'(rd_addr_q[0]), 32'd0);
            for (int i = 0; i < LEN; i++)
                chk("B_rd_addr", 32'(rd_addr_q[1+i]), 32'(16'hD000 + 16'(i)));
        end
        check_writes(8'hF0, 0, LEN);
        chk("B_regrd", 32'(reg_data_read), 32'hF0);

        // No responder: every byte becomes FF
        force_invalid = 1'b1;
        clear_log();
        trigger(8'hC1);
        wait_idle(400);
        chk("C_strobes", 32'(wr_addr_q.size()), 32'd160);
        foreach (wr_data_q[i]) chk("C_ff", 32'(wr_data_q[i]), 32'hFF);
        force_invalid = 1'b0;

        // Retrigger at the 50th WRITE
        for (int i = 0; i < LEN; i++) valid_map[16'hC200 + 16'(i)] = 1'b1;
        clear_log();
        trigger(8'hC1);
        retrigger(8'hC2, 50);
        wait_idle(800);
        chk("D_strobes", 32'(wr_addr_q.size()), 32'd210);
        chk("D_active_cycles", 32'(active_cnt), 32'd422);
        chk("D_falls", 32'(falls), 32'd1);
        check_writes(8'hC1, 0, 50);
        check_writes(8'hC2, 50, LEN);

        // Retrigger during the final WRITE
        clear_log();
        trigger(8'hC1);
        retrigger(8'hC2, 160);
        wait_idle(1000);
        chk("E_strobes", 32'(wr_addr_q.size()), 32'd320);
        chk("E_active_cycles", 32'(active_cnt), 32'd642);
        chk("E_falls", 32'(falls), 32'd1);
        check_writes(8'hC1, 0, LEN);
        check_writes(8'hC2, LEN, LEN);

        // Reset during the 10th READ
        clear_log();
        trigger(8'hC1);
        begin
            int n = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (dma_active && !dma_do_write && dma_addr != 16'h0000) n++;
                if (n == 10) break;
            end
            chk("F_reach_read10", 32'(n), 32'd10);
        end
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("F_strobes", 32'(wr_addr_q.size()), 32'd9);
        chk("F_active_cycles", 32'(active_cnt), 32'd20);
        chk("F_idle_after", 32'(dma_active), 32'd0);
        chk("F_regrd", 32'(reg_data_read), 32'd0);
        clear_log();
        trigger(8'hC2);
        wait_idle(400);
        chk("F_restart_strobes", 32'(wr_addr_q.size()), 32'd160);

        // Randomized transfers, including mapping boundaries
        for (int r = 0; r < 6; r++) begin
            logic [7:0] s;
            s = 8'($urandom);
            if (r == 0) s = 8'hFF;
            if (r == 1) s = 8'hE0;
            if (r == 2) s = 8'hDF;
            clear_log();
            trigger(s);
            wait_idle(400);
            chk("R_active_cycles", 32'(active_cnt), 32'd321);
            chk("R_strobes", 32'(wr_addr_q.size()), 32'd160);
            check_writes(s, 0, LEN);
            chk("R_regrd", 32'(reg_data_read), 32'(s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
